// File: rtl/data_bus_responder_pkg.sv
// Shared data-bus address map: region pages, MMIO register offsets and
// CTRL/STATUS bit positions. The CPU imports this to reach the timer block.
package data_bus_responder_pkg;

   // a[31:8] selects the region; a[7:0] is the byte offset inside it
   localparam logic [23:0] RAM_PAGE  = 24'h000000;
   localparam logic [23:0] MMIO_PAGE = 24'h000001;

   // MMIO register byte offsets inside the MMIO page
   localparam logic [7:0] REG_CTRL    = 8'h00;
   localparam logic [7:0] REG_COUNT   = 8'h04;
   localparam logic [7:0] REG_COMPARE = 8'h08;
   localparam logic [7:0] REG_STATUS  = 8'h0C;
   localparam logic [7:0] REG_WRCNT   = 8'h10;

   // CTRL bits
   localparam int CTRL_EN         = 0;
   localparam int CTRL_AUTORELOAD = 1;
   localparam int CTRL_IRQEN      = 2;
   localparam int CTRL_BITS       = 3;

   // STATUS bits
   localparam int STATUS_MATCH  = 0;
   localparam int STATUS_BUSERR = 1;

   localparam logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      REGION_RAM,
      REGION_MMIO,
      REGION_NONE
   } region_e;

   // Map the upper address bits to the region they select
   function automatic region_e decode_region(input logic [23:0] page);
      if (page == RAM_PAGE)       return REGION_RAM;
      else if (page == MMIO_PAGE) return REGION_MMIO;
      else                        return REGION_NONE;
   endfunction

endpackage

// File: rtl/data_bus_responder_if.sv
// CPU MEM-stage data bus: address, store data, {write,read} strobes and
// combinational read data.
interface data_bus_responder_if;
   logic [31:0] a;
   logic [31:0] d;
   logic [1:0]  we;
   logic [31:0] spo;

   modport master (output a, output d, output we, input spo);
   modport slave  (input a, input d, input we, output spo);
endinterface

// File: rtl/data_bus_responder_ram.sv
// Data RAM: RAM_WORDS x 32, synchronous write, asynchronous read.
// Contents survive reset; they start as zero at power-up / sim start.
module dbus_ram #(
   parameter int RAM_WORDS = 64,
   parameter int AW        = 6
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [RAM_WORDS] = '{default: '0};

   // Commit the store on the clock edge; reads see the pre-edge word
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/data_bus_responder.sv
// Data-bus responder: data RAM plus a small timer MMIO block
// (CTRL/COUNT/COMPARE/STATUS/WRCNT) with a registered match interrupt.
module data_bus_responder
   import data_bus_responder_pkg::*;
#(
   parameter int RAM_WORDS = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   data_bus_responder_if.slave   bus,
   output logic                  irq
);

   localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

   region_e             region;
   logic [7:0]          reg_off;
   logic                wr_cmt;
   logic                ram_we;
   logic                wr_mmio;
   logic                wr_ctrl, wr_count, wr_compare, wr_status;
   logic                bus_err_evt;
   logic                wr_accepted;
   logic                match_evt;
   logic [31:0]         ram_rdata;
   logic [31:0]         spo_c;

   logic [CTRL_BITS-1:0] ctrl;
   logic [31:0]          count;
   logic [31:0]          compare;
   logic                 st_match;
   logic                 st_buserr;
   logic [31:0]          wrcnt;

   // Byte lane bits and the read strobe have no effect on this block
   logic unused_bits;
   assign unused_bits = ^{bus.a[1:0], bus.we[0]};

   // ---- decode ------------------------------------------------------------
   assign region  = decode_region(bus.a[31:8]);
   assign reg_off = {bus.a[7:2], 2'b00};

   // Writes while reset is high are dropped entirely
   assign wr_cmt     = bus.we[1] & ~reset;
   assign ram_we     = wr_cmt && (region == REGION_RAM);
   assign wr_mmio    = wr_cmt && (region == REGION_MMIO);
   assign wr_ctrl    = wr_mmio && (reg_off == REG_CTRL);
   assign wr_count   = wr_mmio && (reg_off == REG_COUNT);
   assign wr_compare = wr_mmio && (reg_off == REG_COMPARE);
   assign wr_status  = wr_mmio && (reg_off == REG_STATUS);

   // WRCNT is read-only, so a store to it is treated like an unmapped store
   assign bus_err_evt = wr_cmt &&
                        ((region == REGION_NONE) ||
                         ((region == REGION_MMIO) && (reg_off == REG_WRCNT)));

   // Other MMIO offsets are silently ignored and are not counted
   assign wr_accepted = ram_we | wr_ctrl | wr_count | wr_compare | wr_status;

   assign match_evt = ctrl[CTRL_EN] && (count == compare);

   // ---- data RAM ----------------------------------------------------------
   dbus_ram #(
      .RAM_WORDS (RAM_WORDS),
      .AW        (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (bus.a[2 +: AW]),
      .wdata (bus.d),
      .rdata (ram_rdata)
   );

   // Control and compare registers: plain CPU-writable state
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl    <= '0;
         compare <= COMPARE_RESET;
      end else begin
         if (wr_ctrl)    ctrl    <= bus.d[CTRL_BITS-1:0];
         if (wr_compare) compare <= bus.d;
      end
   end

   // Timer counter: CPU store wins, else reload-on-match or free-run increment
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (wr_count) begin
         count <= bus.d;
      end else if (ctrl[CTRL_EN]) begin
         if (match_evt && ctrl[CTRL_AUTORELOAD]) count <= '0;
         else                                    count <= count + 32'd1;
      end
   end

   // Sticky STATUS bits, write-1-to-clear; a same-cycle set beats the clear
   always_ff @(posedge clk) begin
      if (reset) begin
         st_match  <= 1'b0;
         st_buserr <= 1'b0;
      end else begin
         if (match_evt)                              st_match  <= 1'b1;
         else if (wr_status && bus.d[STATUS_MATCH])  st_match  <= 1'b0;
         if (bus_err_evt)                            st_buserr <= 1'b1;
         else if (wr_status && bus.d[STATUS_BUSERR]) st_buserr <= 1'b0;
      end
   end

   // Accepted-write counter and registered interrupt
   always_ff @(posedge clk) begin
      if (reset) begin
         wrcnt <= '0;
         irq   <= 1'b0;
      end else begin
         if (wr_accepted) wrcnt <= wrcnt + 32'd1;
         irq <= st_match & ctrl[CTRL_IRQEN];
      end
   end

   // Combinational read mux; unmapped space and unused offsets read zero
   always_comb begin
      spo_c = '0;
      case (region)
         REGION_RAM:  spo_c = ram_rdata;
         REGION_MMIO: begin
            case (reg_off)
               REG_CTRL:    spo_c = {{(32-CTRL_BITS){1'b0}}, ctrl};
               REG_COUNT:   spo_c = count;
               REG_COMPARE: spo_c = compare;
               REG_STATUS:  spo_c = {30'd0, st_buserr, st_match};
               REG_WRCNT:   spo_c = wrcnt;
               default:     spo_c = '0;
            endcase
         end
         default:     spo_c = '0;
      endcase
   end

   assign bus.spo = spo_c;

endmodule

// File: doc/data_bus_responder.md
DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 64, meaning number of 32-bit data RAM words (power of two, max 64).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port a  input  32  byte address from CPU MEM stage (ALUResult_mem).
REQ-005 SHALL have port d  input  32  store data from CPU.
REQ-006 SHALL have port we  input  2  {MemWrite, MemRead}; bit1 = write strobe, bit0 = read strobe.
REQ-007 SHALL have port spo  output  32  read data, combinational from a (CPU MemDout_mem).
REQ-008 SHALL have port irq  output  1  timer match interrupt, registered.

Function
REQ-009 SHALL decode word address (a[1:0] ignored): a[31:8]==0 -> RAM, index a[7:2] modulo RAM_WORDS; a[31:8]==24'h000001 -> MMIO; else unmapped.
REQ-010 SHALL provide MMIO registers: 0x100 CTRL (bit0 EN, bit1 AUTORELOAD, bit2 IRQEN, others read 0), 0x104 COUNT, 0x108 COMPARE, 0x10C STATUS (bit0 MATCH, bit1 BUSERR), 0x110 WRCNT (read-only count of accepted writes); other MMIO offsets read 0, writes ignored.
REQ-011 SHALL drive spo combinationally in the same cycle from a, regardless of we; unmapped addresses read 0.
REQ-012 SHALL commit a write when we[1]=1 at the clock edge; we[0] has no side effects; we=2'b11 treated as write.
REQ-013 SHALL return the pre-edge value on a same-cycle read of a location being written (read-before-write).
REQ-014 SHALL increment COUNT by 1 per cycle while EN=1, wrapping 32'hFFFFFFFF -> 0.
REQ-015 SHALL set MATCH on the edge after a cycle where EN=1 and COUNT==COMPARE; when AUTORELOAD=1 that same edge loads COUNT with 0 instead of incrementing.
REQ-016 SHALL give a CPU write to COUNT priority over increment/reload in the same cycle.
REQ-017 SHALL clear STATUS bits written with 1 (W1C); a set event in the same cycle wins over clear.
REQ-018 SHALL set BUSERR on any write to an unmapped address or to WRCNT; such writes change no other state.
REQ-019 SHALL increment WRCNT (wrapping) for every committed write to RAM or writable MMIO register.
REQ-020 SHALL register irq = MATCH & IRQEN, one cycle after either changes.

Reset
REQ-021 SHALL, while reset=1 at an edge, clear CTRL, COUNT, STATUS, WRCNT and irq to 0, and set COMPARE to 32'hFFFFFFFF; writes during reset are dropped.
REQ-022 SHALL NOT clear RAM contents on reset; RAM initial content 0 at simulation start.
REQ-023 SHALL, after reset, have spo reflect reset values of MMIO registers (e.g. COMPARE reads 32'hFFFFFFFF).

Structure
REQ-024 SHALL place address-map constants (region bases, register offsets, CTRL/STATUS bit positions) in the shared package used by the CPU.
REQ-025 SHALL instantiate one sub-module dbus_ram (RAM_WORDS x 32, synchronous write, asynchronous read); MMIO logic stays in data_bus_responder.
REQ-026 SHALL be a drop-in replacement for the CPU data RAM instance (same a/d/we/spo connectivity).

Verification
REQ-027 SHALL cover: write 0xDEADBEEF to 0x08 -> next cycle read 0x08 gives 0xDEADBEEF, WRCNT=1; read 0x0C gives 0.
REQ-028 SHALL cover: COMPARE=5, CTRL=0b101 -> COUNT counts 0..5, MATCH set edge after COUNT==5, irq high one cycle later; write 1 to STATUS -> MATCH and irq clear.
REQ-029 SHALL cover: COMPARE=3, CTRL=0b011 -> COUNT sequence 0,1,2,3,0,1,... and MATCH set at first reload.
REQ-030 SHALL cover: EN=1, write COUNT=0xFFFFFFFE -> next cycles 0xFFFFFFFE, 0xFFFFFFFF, 0; write to COUNT while EN overrides increment.
REQ-031 SHALL cover: write to 0x0000_1000 and to 0x110 -> BUSERR=1, WRCNT unchanged, reads return 0 and WRCNT value respectively.
REQ-032 SHALL cover: reset asserted mid-count with write pending -> all MMIO at reset values next cycle, RAM word written earlier preserved, pending write dropped.
